header_rx_assembler: RTL

HEADER_RX_ASSEMBLER -- requirements
Module: header_rx_assembler

---
 rtl/miner_pkg.sv | 15 +
 rtl/uart_rx_handshake.sv | 33 +++
 rtl/header_rx_assembler.sv | 104 ++++++++++
 3 files changed

// File: rtl/miner_pkg.sv
// Shared miner definitions: header geometry, receive FSM encoding
// and the default idle timeout used by the header receive path.
package miner_pkg;

  localparam int HEADER_BITS = 640;
  localparam int TIMEOUT_DEF = 5_000_000;
  localparam int IDLE_W      = 23;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_COMMIT = 2'd2
  } rx_state_e;

endpackage

// File: rtl/uart_rx_handshake.sv
// Byte-ready / clear handshake with the UART receiver:
// one accepted byte per rx_rdy assertion, one-cycle clear strobe back.
module uart_rx_handshake (
  input  logic clock,
  input  logic reset,
  input  logic rx_rdy_i,
  input  logic en_i,
  output logic rdy_clr_o,
  output logic byte_strobe_o
);

  logic rdy_clr_q;
  logic armed_q;

  // re-arm only after rx_rdy has been seen low
  assign byte_strobe_o = rx_rdy_i & armed_q
                       & ~rdy_clr_q & en_i;
  assign rdy_clr_o     = rdy_clr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdy_clr_q <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      rdy_clr_q <= byte_strobe_o;
      if (byte_strobe_o)
        armed_q <= 1'b0;
      else if (!rx_rdy_i)
        armed_q <= 1'b1;
    end
  end

endmodule

// File: rtl/header_rx_assembler.sv
// Assembles UART bytes into a block header, MSB-first, with an
// idle timeout that discards partial headers.
module header_rx_assembler
  import miner_pkg::*;
#(
  parameter int HEADER_BYTES   = HEADER_BITS / 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_rdy,
  output logic                      rdy_clr,
  output logic [HEADER_BYTES*8-1:0] header_data,
  output logic                      header_valid,
  output logic [6:0]                byte_count,
  output logic                      timeout_err
);

  localparam int HB = HEADER_BYTES * 8;
  localparam logic [6:0] LAST =
    7'(HEADER_BYTES - 1);
  localparam logic [IDLE_W-1:0] TO_LAST =
    IDLE_W'(TIMEOUT_CYCLES - 1);

  rx_state_e         state_q;
  logic [6:0]        cnt_q;
  logic [IDLE_W-1:0] idle_q;
  logic [HB-1:0]     shadow_q;
  logic [HB-1:0]     shadow_d;
  logic [HB-1:0]     hdr_q;
  logic              hv_q;
  logic              to_q;
  logic              strobe;
  logic              accept_en;

  assign accept_en = (state_q != ST_COMMIT);
  assign shadow_d  = {shadow_q[HB-9:0], rx_data};

  uart_rx_handshake u_hs (
    .clock         (clock),
    .reset         (reset),
    .rx_rdy_i      (rx_rdy),
    .en_i          (accept_en),
    .rdy_clr_o     (rdy_clr),
    .byte_strobe_o (strobe)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idle_q   <= '0;
      shadow_q <= '0;
      hdr_q    <= '0;
      hv_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      hv_q <= 1'b0;
      to_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (strobe) begin
            shadow_q <= shadow_d;
            cnt_q    <= 7'd1;
            idle_q   <= '0;
            state_q  <= ST_RECV;
          end
        end
        ST_RECV: begin
          // an accepted byte always beats the timeout
          if (strobe) begin
            shadow_q <= shadow_d;
            idle_q   <= '0;
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              hdr_q   <= shadow_d;
              hv_q    <= 1'b1;
              state_q <= ST_COMMIT;
            end else begin
              cnt_q <= cnt_q + 7'd1;
            end
          end else if (idle_q == TO_LAST) begin
            to_q     <= 1'b1;
            cnt_q    <= '0;
            shadow_q <= '0;
            idle_q   <= '0;
            state_q  <= ST_IDLE;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        ST_COMMIT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign header_data  = hdr_q;
  assign header_valid = hv_q;
  assign timeout_err  = to_q;
  assign byte_count   = cnt_q;

endmodule
